// File: rtl/tpu_tile_scheduler.sv
// Tile-level sequencer: walks an M x N grid of output tiles, launching the
// systolic controller once per tile and stepping the per-tile SRAM base addresses.
module tpu_tile_scheduler #(
  parameter int TILE_CNT_W = 4,
  parameter int ADDR_W     = 10,
  parameter int A_STRIDE   = 128,
  parameter int B_STRIDE   = 128,
  parameter int OUT_STRIDE = 64
) (
  input  logic                    clk,
  input  logic                    srstn,
  input  logic                    host_start,
  input  logic                    host_abort,
  input  logic [TILE_CNT_W-1:0]   cfg_tiles_m,
  input  logic [TILE_CNT_W-1:0]   cfg_tiles_n,
  input  logic                    tpu_done,
  output logic                    tpu_start,
  output logic [TILE_CNT_W-1:0]   tile_m,
  output logic [TILE_CNT_W-1:0]   tile_n,
  output logic [ADDR_W-1:0]       a_base_addr,
  output logic [ADDR_W-1:0]       b_base_addr,
  output logic [ADDR_W-1:0]       out_base_addr,
  output logic [2*TILE_CNT_W-1:0] tiles_done,
  output logic                    busy,
  output logic                    all_done,
  output logic                    aborted
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0]       LP_A_STEP   = ADDR_W'(A_STRIDE);
  localparam logic [ADDR_W-1:0]       LP_B_STEP   = ADDR_W'(B_STRIDE);
  localparam logic [ADDR_W-1:0]       LP_OUT_STEP = ADDR_W'(OUT_STRIDE);
  localparam logic [TILE_CNT_W-1:0]   LP_TILE_ONE = TILE_CNT_W'(1);
  localparam logic [2*TILE_CNT_W-1:0] LP_CNT_ONE  = (2*TILE_CNT_W)'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [TILE_CNT_W-1:0]   r_cfg_m;
  logic [TILE_CNT_W-1:0]   r_cfg_n;
  logic [TILE_CNT_W-1:0]   r_tile_m;
  logic [TILE_CNT_W-1:0]   r_tile_n;
  logic [ADDR_W-1:0]       r_a_base;
  logic [ADDR_W-1:0]       r_b_base;
  logic [ADDR_W-1:0]       r_out_base;
  logic [2*TILE_CNT_W-1:0] r_tiles_done;
  logic                    r_tpu_start;
  logic                    r_busy;
  logic                    r_all_done;
  logic                    r_aborted;
  logic                    r_abort_pend;
  logic                    w_cfg_zero;
  logic                    w_last_tile;
  logic                    w_abort_now;

  assign w_cfg_zero  = (cfg_tiles_m == '0) || (cfg_tiles_n == '0);
  assign w_last_tile = (r_tile_m == r_cfg_m - LP_TILE_ONE) &&
                       (r_tile_n == r_cfg_n - LP_TILE_ONE);
  // An abort arriving together with tpu_done counts as already pending.
  assign w_abort_now = r_abort_pend || host_abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (host_start && !w_cfg_zero) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    if (tpu_done) w_next = (w_last_tile || w_abort_now) ? S_DONE : S_NEXT;
      S_NEXT:   w_next = S_LAUNCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state      <= S_IDLE;
      r_cfg_m      <= '0;
      r_cfg_n      <= '0;
      r_tile_m     <= '0;
      r_tile_n     <= '0;
      r_a_base     <= '0;
      r_b_base     <= '0;
      r_out_base   <= '0;
      r_tiles_done <= '0;
      r_tpu_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_all_done   <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tpu_start <= (w_next == S_LAUNCH);
      r_busy      <= (w_next != S_IDLE);
      r_all_done  <= (w_next == S_DONE) ||
                     ((r_state == S_IDLE) && host_start && w_cfg_zero);
      if (host_abort && ((r_state == S_LAUNCH) || (r_state == S_RUN) || (r_state == S_NEXT)))
        r_abort_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (host_start) begin
            r_aborted <= 1'b0;
            if (!w_cfg_zero) begin
              r_cfg_m      <= cfg_tiles_m;
              r_cfg_n      <= cfg_tiles_n;
              r_tile_m     <= '0;
              r_tile_n     <= '0;
              r_a_base     <= '0;
              r_b_base     <= '0;
              r_out_base   <= '0;
              r_tiles_done <= '0;
              r_abort_pend <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (tpu_done) begin
            r_tiles_done <= r_tiles_done + LP_CNT_ONE;
            if (w_next == S_DONE) r_aborted <= w_abort_now;
          end
        end
        S_NEXT: begin
          // Column index runs fastest; wrapping it steps to the next tile row.
          if (r_tile_n != r_cfg_n - LP_TILE_ONE) begin
            r_tile_n <= r_tile_n + LP_TILE_ONE;
            r_b_base <= r_b_base + LP_B_STEP;
          end else begin
            r_tile_n <= '0;
            r_b_base <= '0;
            r_tile_m <= r_tile_m + LP_TILE_ONE;
            r_a_base <= r_a_base + LP_A_STEP;
          end
          r_out_base <= r_out_base + LP_OUT_STEP;
        end
        S_DONE:  r_abort_pend <= 1'b0;
        default: ;
      endcase
    end
  end

  assign tpu_start     = r_tpu_start;
  assign tile_m        = r_tile_m;
  assign tile_n        = r_tile_n;
  assign a_base_addr   = r_a_base;
  assign b_base_addr   = r_b_base;
  assign out_base_addr = r_out_base;
  assign tiles_done    = r_tiles_done;
  assign busy          = r_busy;
  assign all_done      = r_all_done;
  assign aborted       = r_aborted;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Bench for tpu_tile_scheduler: a default instance and an 8-bit-address instance
// share stimulus; expected tile order and addresses come from grid arithmetic.
module tb_tpu_tile_scheduler;

  localparam int AS = 128;
  localparam int BS = 128;
  localparam int OS = 64;

  logic       clk;
  logic       srstn, hostStart, hostAbort, tpuDone;
  logic [3:0] cfgM, cfgN;

  logic       tpuStart, busy, allDone, aborted;
  logic [3:0] tileM, tileN;
  logic [9:0] aBase, bBase, outBase;
  logic [7:0] tilesDone;

  logic       tpuStart8, busy8, allDone8, aborted8;
  logic [3:0] tileM8, tileN8;
  logic [7:0] aBase8, bBase8, outBase8;
  logic [7:0] tilesDone8;

  logic [93:0] allOut;
  logic [37:0] tileVec;
  logic [23:0] addrVec8;

  int total = 0;
  int bad = 0;
  int startCount = 0;
  int lastT = 0;

  tpu_tile_scheduler u_dut (
    .clk(clk), .srstn(srstn), .host_start(hostStart), .host_abort(hostAbort),
    .cfg_tiles_m(cfgM), .cfg_tiles_n(cfgN), .tpu_done(tpuDone),
    .tpu_start(tpuStart), .tile_m(tileM), .tile_n(tileN),
    .a_base_addr(aBase), .b_base_addr(bBase), .out_base_addr(outBase),
    .tiles_done(tilesDone), .busy(busy), .all_done(allDone), .aborted(aborted)
  );

  tpu_tile_scheduler #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .srstn(srstn), .host_start(hostStart), .host_abort(hostAbort),
    .cfg_tiles_m(cfgM), .cfg_tiles_n(cfgN), .tpu_done(tpuDone),
    .tpu_start(tpuStart8), .tile_m(tileM8), .tile_n(tileN8),
    .a_base_addr(aBase8), .b_base_addr(bBase8), .out_base_addr(outBase8),
    .tiles_done(tilesDone8), .busy(busy8), .all_done(allDone8), .aborted(aborted8)
  );

  assign allOut   = {tpuStart, tileM, tileN, aBase, bBase, outBase, tilesDone, busy, allDone, aborted,
                     tpuStart8, tileM8, tileN8, aBase8, bBase8, outBase8, tilesDone8, busy8, allDone8, aborted8};
  assign tileVec  = {tileM, tileN, aBase, bBase, outBase};
  assign addrVec8 = {aBase8, bBase8, outBase8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (tpuStart) startCount <= startCount + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    srstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hostStart = 1'($urandom); hostAbort = 1'($urandom); tpuDone = 1'($urandom);
      cfgM = 4'($urandom); cfgN = 4'($urandom);
      tick;
      total++;
      if (allOut !== '0) begin
        bad++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h want 0", i, allOut);
      end
    end
    hostStart = 1'b0; hostAbort = 1'b0; tpuDone = 1'b0; cfgM = 4'd0; cfgN = 4'd0;
    srstn = 1'b1;
    tick;
    total++;
    if (allOut !== '0 || startCount !== 0) begin
      bad++;
      $display("[TB] FAIL reset_release: got %h starts=%0d want 0", allOut, startCount);
    end
  endtask

  // One whole job, checked tile by tile against row-major grid arithmetic.
  task automatic run_job(input int m, input int n, input int lat, input int abortTile,
                         input bit abortWithDone, input bit holdStart, input bit spurious,
                         input int resetTile);
    int          fullT, numT, s0, tm, tn;
    bit          expAbort;
    logic [37:0] expVec;
    logic [23:0] exp8;
    fullT = m * n;
    if (abortTile >= 0 && abortTile < fullT) begin
      numT = abortTile + 1; expAbort = 1'b1;
    end else begin
      numT = fullT; expAbort = 1'b0;
    end
    s0 = startCount;
    hostStart = 1'b1; cfgM = 4'(m); cfgN = 4'(n);
    tick;
    if (!holdStart) hostStart = 1'b0;
    cfgM = 4'($urandom); cfgN = 4'($urandom);
    for (int t = 0; t < numT; t++) begin
      tm = t / n; tn = t % n;
      expVec = {4'(tm), 4'(tn), 10'(tm * AS), 10'(tn * BS), 10'(t * OS)};
      exp8   = {8'(tm * AS), 8'(tn * BS), 8'(t * OS)};
      total++;
      if (tpuStart !== 1'b1 || busy !== 1'b1 || allDone !== 1'b0 || tilesDone !== 8'(t)) begin
        bad++;
        $display("[TB] FAIL launch tile %0d: start=%b busy=%b done=%b tiles=%0d want 1 1 0 %0d",
                 t, tpuStart, busy, allDone, tilesDone, t);
      end
      total++;
      if (tileVec !== expVec || addrVec8 !== exp8) begin
        bad++;
        $display("[TB] FAIL tile_addr tile %0d: got %h/%h want %h/%h", t, tileVec, addrVec8, expVec, exp8);
      end
      if (spurious) tpuDone = 1'b1;
      tick;
      tpuDone = 1'b0;
      for (int c = 1; c < lat; c++) begin
        if (t == resetTile && c == 1) begin
          srstn = 1'b0;
          tick;
          total++;
          if (allOut !== '0) begin
            bad++;
            $display("[TB] FAIL midjob_reset: got %h want 0", allOut);
          end
          tick;
          srstn = 1'b1; hostStart = 1'b0;
          for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if (tpuStart !== 1'b0 || busy !== 1'b0) begin
              bad++;
              $display("[TB] FAIL post_reset_idle: start=%b busy=%b want 0 0", tpuStart, busy);
            end
          end
          lastT = 0;
          return;
        end
        if (c == 1 && t == abortTile && !abortWithDone) hostAbort = 1'b1;
        tick;
        hostAbort = 1'b0;
        total++;
        if (tpuStart !== 1'b0 || tileVec !== expVec) begin
          bad++;
          $display("[TB] FAIL run_stable tile %0d: start=%b vec=%h want 0 %h", t, tpuStart, tileVec, expVec);
        end
      end
      tpuDone = 1'b1;
      if (t == abortTile && abortWithDone) hostAbort = 1'b1;
      tick;
      tpuDone = 1'b0; hostAbort = 1'b0;
      total++;
      if (tilesDone !== 8'(t + 1)) begin
        bad++;
        $display("[TB] FAIL tiles_done tile %0d: got %0d want %0d", t, tilesDone, t + 1);
      end
      if (t == numT - 1) begin
        total++;
        if (allDone !== 1'b1 || busy !== 1'b1 || aborted !== expAbort || tpuStart !== 1'b0) begin
          bad++;
          $display("[TB] FAIL done_cycle: all_done=%b busy=%b aborted=%b start=%b want 1 1 %b 0",
                   allDone, busy, aborted, tpuStart, expAbort);
        end
        tick;
        hostStart = 1'b0;
        total++;
        if (allDone !== 1'b0 || busy !== 1'b0 || tpuStart !== 1'b0 || aborted !== expAbort) begin
          bad++;
          $display("[TB] FAIL idle_after: all_done=%b busy=%b start=%b aborted=%b want 0 0 0 %b",
                   allDone, busy, tpuStart, aborted, expAbort);
        end
        total++;
        if (startCount - s0 !== numT) begin
          bad++;
          $display("[TB] FAIL start_count: got %0d want %0d", startCount - s0, numT);
        end
        lastT = numT;
      end else begin
        total++;
        if (tpuStart !== 1'b0 || allDone !== 1'b0 || busy !== 1'b1 || tileVec !== expVec) begin
          bad++;
          $display("[TB] FAIL next_cycle tile %0d: start=%b done=%b busy=%b vec=%h want 0 0 1 %h",
                   t, tpuStart, allDone, busy, tileVec, expVec);
        end
        if (spurious) tpuDone = 1'b1;
        tick;
        tpuDone = 1'b0;
      end
    end
  endtask

  task automatic test_basic;
    run_job(2, 3, 20, -1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort;
    run_job(1, 4, 6, 1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort_with_last;
    run_job(2, 2, 3, 3, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_zero_count;
    int s0;
    s0 = startCount;
    hostStart = 1'b1; cfgM = 4'd0; cfgN = 4'd5;
    tick;
    hostStart = 1'b0;
    total++;
    if (allDone !== 1'b1 || busy !== 1'b0 || tpuStart !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_count: all_done=%b busy=%b start=%b aborted=%b want 1 0 0 0",
               allDone, busy, tpuStart, aborted);
    end
    tick;
    total++;
    if (allDone !== 1'b0 || busy !== 1'b0 || tpuStart !== 1'b0 || startCount !== s0) begin
      bad++;
      $display("[TB] FAIL zero_count_after: all_done=%b busy=%b start=%b starts=%0d want 0 0 0 %0d",
               allDone, busy, tpuStart, startCount, s0);
    end
  endtask

  task automatic test_back_to_back;
    run_job(2, 2, 4, -1, 1'b0, 1'b1, 1'b1, -1);
    run_job(3, 2, 3, -1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_spurious_idle;
    tpuDone = 1'b1;
    tick;
    tick;
    tpuDone = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || tpuStart !== 1'b0 || allDone !== 1'b0 || tilesDone !== 8'(lastT)) begin
      bad++;
      $display("[TB] FAIL spurious_idle: busy=%b start=%b done=%b tiles=%0d want 0 0 0 %0d",
               busy, tpuStart, allDone, tilesDone, lastT);
    end
  endtask

  task automatic test_wrap;
    run_job(3, 1, 3, -1, 1'b0, 1'b0, 1'b0, -1);
    run_job(10, 1, 2, -1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    int m, n, lat, ab;
    for (int j = 0; j < 8; j++) begin
      m   = int'($urandom_range(1, 10));
      n   = int'($urandom_range(1, 3));
      lat = int'($urandom_range(2, 6));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, m * n - 1)) : -1;
      run_job(m, n, lat, ab, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1), -1);
    end
  endtask

  task automatic test_reset_midjob;
    run_job(3, 2, 5, -1, 1'b0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    srstn = 1'b0; hostStart = 1'b0; hostAbort = 1'b0; tpuDone = 1'b0;
    cfgM = 4'd0; cfgN = 4'd0;
    test_reset;
    test_basic;
    test_abort;
    test_zero_count;
    test_back_to_back;
    test_spurious_idle;
    test_abort_with_last;
    test_wrap;
    test_random;
    test_reset_midjob;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
